// File: rtl/sram_arb.sv
// Single-port SRAM arbiter: fixed CPU priority with a DMA anti-starvation override,
// plus a one-deep read-owner pipeline that steers returning read data to its requester.
module sram_arb #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_gnt,
  output logic              o_cpu_rvalid,
  output logic [DATA_W-1:0] o_cpu_rdata,
  input  logic              i_dma_req,
  input  logic              i_dma_we,
  input  logic [ADDR_W-1:0] i_dma_addr,
  input  logic [DATA_W-1:0] i_dma_wdata,
  output logic              o_dma_gnt,
  output logic              o_dma_rvalid,
  output logic [DATA_W-1:0] o_dma_rdata,
  output logic [ADDR_W-1:0] o_sram_ADDR,
  output logic [DATA_W-1:0] o_sram_DI,
  output logic              o_sram_EN,
  output logic              o_sram_WE,
  input  logic [DATA_W-1:0] i_sram_DO,
  output logic [3:0]        o_starve_cnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]        r_starve_cnt;
  logic              r_rd_valid;
  logic              r_rd_owner;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dma_rdata;

  logic              w_dma_force;
  logic              w_cpu_gnt;
  logic              w_dma_gnt;
  logic [3:0]        w_starve_nxt;

  // Grants are gated by reset so the SRAM side goes quiet the instant reset asserts.
  always_comb begin
    w_dma_force = i_dma_req && (r_starve_cnt == LIMIT);
    w_cpu_gnt   = i_rst_n && i_cpu_req && !w_dma_force;
    w_dma_gnt   = i_rst_n && i_dma_req && (!i_cpu_req || w_dma_force);

    o_sram_ADDR = '0;
    o_sram_DI   = '0;
    o_sram_EN   = 1'b0;
    o_sram_WE   = 1'b0;
    if (w_cpu_gnt) begin
      o_sram_ADDR = i_cpu_addr;
      o_sram_DI   = i_cpu_wdata;
      o_sram_EN   = 1'b1;
      o_sram_WE   = i_cpu_we;
    end else if (w_dma_gnt) begin
      o_sram_ADDR = i_dma_addr;
      o_sram_DI   = i_dma_wdata;
      o_sram_EN   = 1'b1;
      o_sram_WE   = i_dma_we;
    end

    w_starve_nxt = r_starve_cnt;
    if (!i_dma_req || w_dma_gnt) begin
      w_starve_nxt = 4'd0;
    end else if (r_starve_cnt < LIMIT) begin
      w_starve_nxt = r_starve_cnt + 4'd1;
    end
  end

  assign o_cpu_gnt    = w_cpu_gnt;
  assign o_dma_gnt    = w_dma_gnt;
  assign o_starve_cnt = r_starve_cnt;

  // Returned data passes straight through to the owner; the other port keeps its last value.
  assign o_cpu_rvalid = r_rd_valid && !r_rd_owner;
  assign o_dma_rvalid = r_rd_valid &&  r_rd_owner;
  assign o_cpu_rdata  = o_cpu_rvalid ? i_sram_DO : r_cpu_rdata;
  assign o_dma_rdata  = o_dma_rvalid ? i_sram_DO : r_dma_rdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve_cnt <= 4'd0;
      r_rd_valid   <= 1'b0;
      r_rd_owner   <= 1'b0;
      r_cpu_rdata  <= '0;
      r_dma_rdata  <= '0;
    end else begin
      r_starve_cnt <= w_starve_nxt;
      r_rd_valid   <= (w_cpu_gnt && !i_cpu_we) || (w_dma_gnt && !i_dma_we);
      r_rd_owner   <= w_dma_gnt;
      r_cpu_rdata  <= o_cpu_rdata;
      r_dma_rdata  <= o_dma_rdata;
    end
  end

endmodule
